// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops one word from the TX FIFO and shifts it out as
// start bit, LSB-first data, optional parity and stop bit(s) on the tx pin.
module uart_tx_engine #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    // Even parity is the plain XOR of the data; odd parity is its inverse.
    function automatic logic parity_calc(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == 1) begin
            parity_calc = ~p;
        end else begin
            parity_calc = p;
        end
    endfunction

    logic [2:0]           state_r;
    logic [2:0]           state_s;
    logic [CNT_W-1:0]     baud_r;
    logic [CNT_W-1:0]     baud_s;
    logic [BIT_W-1:0]     bit_idx_r;
    logic [BIT_W-1:0]     bit_idx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_s;
    logic                 parity_r;
    logic                 parity_s;
    logic                 tx_r;
    logic                 tx_s;
    logic                 rd_en_r;
    logic                 rd_en_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 done_r;
    logic                 done_s;
    logic                 bit_end_s;

    assign bit_end_s = (baud_r == CNT_LAST);

    // Next-state, counter and datapath decode; outputs are derived from the next state
    // so that every output pin comes straight from a flop.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        parity_s  = parity_r;
        rd_en_s   = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_s    = {CNT_W{1'b0}};
                bit_idx_s = {BIT_W{1'b0}};
                if (tx_en && !fifo_empty) begin
                    state_s = ST_FETCH;
                    rd_en_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                shift_s  = fifo_data;
                parity_s = parity_calc(fifo_data);
                baud_s   = {CNT_W{1'b0}};
                state_s  = ST_START;
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_s    = {CNT_W{1'b0}};
                    bit_idx_s = {BIT_W{1'b0}};
                    state_s   = ST_DATA;
                end else begin
                    baud_s = baud_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_s  = {CNT_W{1'b0}};
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_s = {BIT_W{1'b0}};
                        if (PARITY != 0) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_STOP;
                        end
                    end else begin
                        bit_idx_s = bit_idx_r + BIT_W'(1);
                    end
                end else begin
                    baud_s = baud_r + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    baud_s    = {CNT_W{1'b0}};
                    bit_idx_s = {BIT_W{1'b0}};
                    state_s   = ST_STOP;
                end else begin
                    baud_s = baud_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // bit_idx doubles as the stop-bit counter here
                if (bit_end_s) begin
                    baud_s = {CNT_W{1'b0}};
                    if (bit_idx_r == STOP_LAST) begin
                        bit_idx_s = {BIT_W{1'b0}};
                        state_s   = ST_IDLE;
                        done_s    = 1'b1;
                    end else begin
                        bit_idx_s = bit_idx_r + BIT_W'(1);
                    end
                end else begin
                    baud_s = baud_r + CNT_W'(1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                baud_s    = {CNT_W{1'b0}};
                bit_idx_s = {BIT_W{1'b0}};
            end
        endcase

        case (state_s)
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shift_s[0];
            ST_PARITY: tx_s = parity_s;
            default:   tx_s = 1'b1;
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= {CNT_W{1'b0}};
            bit_idx_r <= {BIT_W{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
            parity_r  <= 1'b0;
            tx_r      <= 1'b1;
            rd_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            parity_r  <= parity_s;
            tx_r      <= tx_s;
            rd_en_r   <= rd_en_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign tx         = tx_r;
    assign fifo_rd_en = rd_en_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
UART transmit serializer sitting directly downstream of the TX FIFO. When the FIFO is non-empty and transmission is enabled, it pops one word and shifts it out on the serial line. Each frame is start bit, data bits LSB first, optional parity, then stop bit(s). It is the only consumer of the TX FIFO read port and drives the chip-level tx pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide), must be >= 2
DATA_BITS, 8, data bits per frame, 5..8; equals FIFO WIDTH
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
tx_en  input  1  when high, new frames may start; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_BITS  FIFO registered read data
fifo_rd_en  output  1  FIFO read strobe, one-cycle pulse per frame
tx  output  1  serial line, idle high
busy  output  1  high from FETCH through the last stop-bit cycle
frame_done  output  1  one-cycle pulse on the cycle after the last stop bit ends

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst is high, regardless of clk:
  - tx=1, fifo_rd_en=0, busy=0, frame_done=0
  - state=IDLE; baud counter, bit index and shift register cleared
- A reset mid-frame aborts the frame immediately. tx returns high with no partial stop bit. A word already popped is lost.
- FIFO read contract: data appears on fifo_data on the clock edge that samples fifo_rd_en=1. It is valid from the following cycle.
- fifo_rd_en is registered and is never high while fifo_empty was high on the sampling edge.
- IDLE:
  - tx=1.
  - If tx_en=1 and fifo_empty=0 at an edge, go to FETCH.
- FETCH: fifo_rd_en=1 for exactly this one cycle; busy=1. Next state is LOAD.
- LOAD: at the edge ending LOAD, shift_reg <= fifo_data and parity_bit is computed; next state is START.
  - parity_bit = XOR of data bits for even parity, its inverse for odd parity.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit; DATA_BITS bits total. Bit index wraps to 0 on exit.
- PARITY: present only if PARITY != 0. tx=parity_bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with frame_done=1 for one cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, reloads 0 at each bit boundary.
  - Width $clog2(CLKS_PER_BIT).
  - Never runs in IDLE, FETCH or LOAD.
- Latency: fifo_empty low at edge E0 gives fifo_rd_en high during E0..E1. tx falls at E2.
- Frame length (tx low to IDLE): (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: minimum inter-frame idle is 3 cycles (IDLE, FETCH, LOAD) of tx=1 after the stop bit(s).
- tx_en dropped mid-frame: the frame completes normally; no new FETCH until tx_en=1.
- fifo_data changes outside LOAD are ignored. The shift register is the only data source during a frame.
- fifo_empty toggling during a frame has no effect.

Test Plan:
- Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clk/bit).
- Reset: assert rst asynchronously between edges -> tx=1, fifo_rd_en=0, busy=0 before the next edge; release with FIFO empty -> tx stays 1 for 200 cycles, fifo_rd_en never pulses.
- Single word 0xA5, PARITY=0, STOP_BITS=1 -> one fifo_rd_en pulse; tx falls 2 cycles after fifo_empty low; bit sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles (100 cycles total); frame_done pulses once; busy covers 102 cycles.
- Parity: 0xA5 with PARITY=2 -> parity bit 0; with PARITY=1 -> parity bit 1; frame 110 cycles. STOP_BITS=2 adds 10 cycles of tx=1 before frame_done.
- Back-to-back: FIFO preloaded with 0x00, 0xFF, 0x3C -> exactly 3 fifo_rd_en pulses; frames decode in order; exactly 3 idle-high cycles between frames; no pop while fifo_empty=1 after the third word.
- tx_en gating: tx_en=0 with FIFO non-empty -> no fifo_rd_en; drop tx_en at cycle 30 of a frame -> frame completes (100 cycles), no next FETCH until tx_en=1.
- Reset mid-frame: assert rst at cycle 45 of a frame -> tx=1 immediately; after release with FIFO non-empty, the next frame starts cleanly with the next FIFO word.
